// File: rtl/common.sv
// Shared definitions for the data-memory responder: operand width,
// RISC-V load/store size codes (funct3) and the responder FSM states.
// The access_error helper holds the misalignment / illegal-size rules in one place.
package common;

  localparam int OPERAND_WIDTH = 32;

  // funct3 size codes for loads and stores.
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dmem_state_t;

  // 1 when the access is misaligned for its size, uses an undefined funct3,
  // or is a store with an unsigned (load-only) size code.
  function automatic logic access_error(input logic       write,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic err;
    case (funct3)
      MEM_B:   err = 1'b0;
      MEM_H:   err = addr_lo[0];
      MEM_W:   err = |addr_lo;
      MEM_BU:  err = write;
      MEM_HU:  err = write | addr_lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// Word-organised storage with per-byte write enables and a registered read port.
// Latency: write lands on the clock edge with we=1; read data appears the cycle after re=1.
// Backpressure: none; rdata_q holds its value until the next re.
// Ports: clk; we/be/addr/wdata write port; re/addr read port; rdata_q read data.
module dmem_lane_ram #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata_q
);

  logic [31:0] mem [DEPTH_WORDS];

  // No reset: contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata_q <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, byte/half/word with sign/zero extension.
// Latency: rsp_valid rises WAIT_CYCLES+1 cycles after request acceptance.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata
//        request channel; rsp_valid/rsp_ready/rsp_rdata/rsp_error response channel.
module dmem_responder
  import common::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [OPERAND_WIDTH-1:0] req_addr,
  input  logic [OPERAND_WIDTH-1:0] req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_error
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  dmem_state_t      state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [AW+1:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic             ram_we;
  logic             ram_re;
  logic [3:0]       ram_be;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;
  logic [31:0]      load_ext;

  // Address bits above the storage range wrap around and are not used.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[OPERAND_WIDTH-1:AW+2];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          funct3_d    = req_funct3;
          addr_d      = req_addr[AW+1:0];
          wdata_d     = req_wdata;
          err_d       = access_error(req_write, req_funct3, req_addr[1:0]);
          cnt_d       = WAIT_LD;
          req_ready_d = 1'b0;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        // Final ACCESS cycle: the store commits and the load samples storage
        // on the same edge, so the response sees any earlier committed store.
        if (cnt_q == 4'd1) begin
          ram_we      = write_q & ~err_q & ~rst;
          ram_re      = ~write_q & ~err_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Store lane steering: replicate the narrow datum across lanes and let the
  // byte enables pick the lanes that actually change.
  always_comb begin
    ram_wdata = wdata_q;
    ram_be    = 4'b0000;
    case (funct3_q)
      MEM_B: begin
        ram_wdata = {4{wdata_q[7:0]}};
        ram_be    = 4'b0001 << addr_q[1:0];
      end
      MEM_H: begin
        ram_wdata = {2{wdata_q[15:0]}};
        ram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      MEM_W: begin
        ram_wdata = wdata_q;
        ram_be    = 4'b1111;
      end
      default: begin
        ram_wdata = wdata_q;
        ram_be    = 4'b0000;
      end
    endcase
  end

  // Load lane selection and extension from the registered read word.
  always_comb begin
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    ld_byte  = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half  = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    load_ext = 32'h0;
    case (funct3_q)
      MEM_B:   load_ext = {{24{ld_byte[7]}}, ld_byte};
      MEM_H:   load_ext = {{16{ld_half[15]}}, ld_half};
      MEM_W:   load_ext = ram_rdata;
      MEM_BU:  load_ext = {24'h0, ld_byte};
      MEM_HU:  load_ext = {16'h0, ld_half};
      default: load_ext = 32'h0;
    endcase
  end

  dmem_lane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .be      (ram_be),
    .re      (ram_re),
    .addr    (addr_q[AW+1:2]),
    .wdata   (ram_wdata),
    .rdata_q (ram_rdata)
  );

  // Response data is forced to zero outside RESP, for stores and for errors;
  // the read word only changes on ram_re, so it is stable through RESP.
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_valid_q & err_q;
  assign rsp_rdata = (rsp_valid_q && !err_q && !write_q) ? load_ext : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_b;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        rdy_a, vld_a, err_a, rdy_b, vld_b, err_b;
  logic [31:0] rd_a, rd_b;
  logic        o_req_ready, o_rsp_valid, o_rsp_error;
  logic [31:0] o_rsp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Instance a: default timing. Instance b: two ACCESS cycles.
  dmem_responder u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid & ~sel),
    .req_ready  (rdy_a),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (vld_a),
    .rsp_ready  (rsp_ready & ~sel),
    .rsp_rdata  (rd_a),
    .rsp_error  (err_a)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut_b (
    .clk        (clk),
    .rst        (rst | rst_b),
    .req_valid  (req_valid & sel),
    .req_ready  (rdy_b),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (vld_b),
    .rsp_ready  (rsp_ready & sel),
    .rsp_rdata  (rd_b),
    .rsp_error  (err_b)
  );

  assign o_req_ready = sel ? rdy_b : rdy_a;
  assign o_rsp_valid = sel ? vld_b : vld_a;
  assign o_rsp_error = sel ? err_b : err_a;
  assign o_rsp_rdata = sel ? rd_b  : rd_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request/response. Expected response is queued at drive time and
  // popped when the DUT raises rsp_valid. hold>0 keeps rsp_ready low while a
  // competing request is presented.
  task automatic txn(input string tag, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err, input int hold);
    exp_t e;
    int   n;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = sel ? 3 : 2;
    sb.push_back(e);
    @(negedge clk);
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_req_ready) begin
      chk({tag, "_rdy_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      void'(sb.pop_back());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!o_rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_rsp_valid) begin
      chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk({tag, "_lat"},   32'(n),             32'(e.lat));
    chk({tag, "_rdata"}, o_rsp_rdata,        e.rdata);
    chk({tag, "_err"},   {31'd0, o_rsp_error}, {31'd0, e.err});
    if (hold > 0) begin
      req_write  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0020;
      req_wdata  = 32'h5A5A_5A5A;
      req_valid  = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, "_hold_vld"}, {31'd0, o_rsp_valid}, 32'd1);
        chk({tag, "_hold_rd"},  o_rsp_rdata,           e.rdata);
        chk({tag, "_hold_rdy"}, {31'd0, o_req_ready},  32'd0);
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, {31'd0, o_rsp_valid}, 32'd0);
    chk({tag, "_idle_rdy"}, {31'd0, o_req_ready}, 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, {31'd0, o_req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, o_rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, o_rsp_rdata,          32'd0);
    chk({tag, "_rsp_error"}, {31'd0, o_rsp_error}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    rst_b      = 1'b0;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("reset_a");
    sel = 1'b1;
    #1;
    chk_idle("reset_b");
    sel = 1'b0;

    //   tag        wr    f3      addr          wdata          exp rdata      err  hold
    txn("sw10",     1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0);
    txn("lw10",     1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
    txn("sb13",     1'b1, 3'b000, 32'h0000_0013, 32'h0000_0080, 32'h0000_0000, 1'b0, 0);
    txn("lb13",     1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'hFFFF_FF80, 1'b0, 0);
    txn("lbu13",    1'b0, 3'b100, 32'h0000_0013, 32'h0,         32'h0000_0080, 1'b0, 0);
    txn("lw10b",    1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h80AD_BEEF, 1'b0, 0);
    txn("lb10",     1'b0, 3'b000, 32'h0000_0010, 32'h0,         32'hFFFF_FFEF, 1'b0, 0);
    txn("lbu11",    1'b0, 3'b100, 32'h0000_0011, 32'h0,         32'h0000_00BE, 1'b0, 0);
    txn("lh12",     1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'hFFFF_80AD, 1'b0, 0);
    txn("lhu12",    1'b0, 3'b101, 32'h0000_0012, 32'h0,         32'h0000_80AD, 1'b0, 0);
    txn("lh11_mis", 1'b0, 3'b001, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1, 0);
    txn("sw12_mis", 1'b1, 3'b010, 32'h0000_0012, 32'h1111_1111, 32'h0000_0000, 1'b1, 0);
    txn("lw10_chk", 1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h80AD_BEEF, 1'b0, 0);
    txn("f3_011",   1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1, 0);
    txn("f3_111",   1'b0, 3'b111, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1, 0);
    txn("sbu_ill",  1'b1, 3'b100, 32'h0000_0010, 32'h0000_0022, 32'h0000_0000, 1'b1, 0);
    txn("lw10_c2",  1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h80AD_BEEF, 1'b0, 0);
    txn("sw14",     1'b1, 3'b010, 32'h0000_0014, 32'h0000_0000, 32'h0000_0000, 1'b0, 0);
    txn("sh16",     1'b1, 3'b001, 32'h0000_0016, 32'h1234_CAFE, 32'h0000_0000, 1'b0, 0);
    txn("lw14",     1'b0, 3'b010, 32'h0000_0014, 32'h0,         32'hCAFE_0000, 1'b0, 0);
    txn("lh16",     1'b0, 3'b001, 32'h0000_0016, 32'h0,         32'hFFFF_CAFE, 1'b0, 0);
    txn("hold",     1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h80AD_BEEF, 1'b0, 5);
    txn("lw20",     1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h80AD_BEEF, 1'b0, 0);
    txn("sw104",    1'b1, 3'b010, 32'h0000_0104, 32'h1234_5678, 32'h0000_0000, 1'b0, 0);
    txn("lw04",     1'b0, 3'b010, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b0, 0);

    // Slow instance: reset in the first ACCESS cycle discards the store.
    sel = 1'b1;
    txn("b_sw08",   1'b1, 3'b010, 32'h0000_0008, 32'hAAAA_5555, 32'h0000_0000, 1'b0, 0);
    txn("b_lw08",   1'b0, 3'b010, 32'h0000_0008, 32'h0,         32'hAAAA_5555, 1'b0, 0);
    @(negedge clk);
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0008;
    req_wdata  = 32'h1111_2222;
    req_valid  = 1'b1;
    chk("b_rst_accept_rdy", {31'd0, o_req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_b     = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    chk_idle("b_after_rst");
    repeat (3) @(negedge clk);
    chk("b_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
    txn("b_lw08_old", 1'b0, 3'b010, 32'h0000_0008, 32'h0,       32'hAAAA_5555, 1'b0, 0);
    txn("b_sb09",   1'b1, 3'b000, 32'h0000_0009, 32'h0000_0077, 32'h0000_0000, 1'b0, 0);
    txn("b_lw08_n", 1'b0, 3'b010, 32'h0000_0008, 32'h0,         32'hAAAA_7755, 1'b0, 0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
